// File: rtl/bus_out_port.sv
// Memory-mapped output port: CPU stores to DATA are queued in a small FIFO and
// presented on a valid/ready stream; loads from STATUS report FIFO flags.
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module bus_out_port #(
    parameter logic [`ADDR_SIZE-1:0] BASE_ADDR = 'hF0,
    parameter int                    DEPTH     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  boot,
    input  logic                  wr_en,
    input  logic [`ADDR_SIZE-1:0] addr,
    inout  wire  [`WORD_SIZE-1:0] data,
    output logic [`WORD_SIZE-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready
);

    localparam int W     = `WORD_SIZE;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [`ADDR_SIZE-1:0] STATUS_ADDR = BASE_ADDR + `ADDR_SIZE'(1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic sel_d;
    logic sel_s;
    logic full;
    logic empty;
    logic push_req;
    logic push;
    logic pop;
    logic ovf_set;
    logic ovf_clr;
    logic drive;
    logic [3:0]   count_sat;
    logic [W-1:0] rd_val;

    assign sel_d = !boot && (addr == BASE_ADDR);
    assign sel_s = !boot && (addr == STATUS_ADDR);

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    assign out_valid = !empty;
    assign out_data  = mem[rd_ptr];

    // A push into a full FIFO is only accepted when the head leaves on the same edge.
    assign pop      = out_valid && out_ready;
    assign push_req = wr_en && sel_d;
    assign push     = push_req && (!full || pop);
    assign ovf_set  = push_req && full && !pop;
    assign ovf_clr  = wr_en && sel_s;

    // NOTE: the storage array has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem[wr_ptr] <= data;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        count_sat = 4'(count);
        if (32'(count) > 32'd15) begin
            count_sat = 4'd15;
        end
        rd_val = '0;
        if (sel_s) begin
            rd_val[7:0] = {count_sat, out_valid && !out_ready, ovf, empty, full};
        end
    end

    // Bus drive is purely combinational from the decode; DATA reads return zero.
    assign drive = !wr_en && (sel_d || sel_s);
    assign data  = drive ? rd_val : {W{1'bz}};

endmodule

// File: tb/tb_bus_out_port.sv
// Scoreboard bench for bus_out_port: stimulus queues expected stream words,
// a negedge monitor compares each accepted word against the queue head.
`timescale 1ns/1ps
`ifndef ADDR_SIZE
`define ADDR_SIZE 8
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module tb_bus_out_port;

    localparam int AW = `ADDR_SIZE;
    localparam int W  = `WORD_SIZE;
    localparam logic [AW-1:0] A_DATA   = AW'('hF0);
    localparam logic [AW-1:0] A_STATUS = AW'('hF1);
    localparam logic [W-1:0]  UNDRIVEN = {W{1'b1}};

    logic          clk = 1'b0;
    logic          rst;
    logic          boot;
    logic          wr_en;
    logic [AW-1:0] addr;
    logic [W-1:0]  out_data;
    logic          out_valid;
    logic          out_ready;
    logic          tb_drive;
    logic [W-1:0]  tb_wdata;
    wire  [W-1:0]  data;

    // Undriven bus floats high so a released bus reads as all ones.
    pullup (data);
    assign data = tb_drive ? tb_wdata : {W{1'bz}};

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    bus_out_port #(.BASE_ADDR(8'hF0), .DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .boot      (boot),
        .wr_en     (wr_en),
        .addr      (addr),
        .data      (data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake must match the oldest outstanding expected word.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL stream_extra: got 'h%0h, expected no word at %0t", out_data, $time);
            end else begin
                check("stream_word", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [AW-1:0] a, input logic [W-1:0] v);
        addr     = a;
        wr_en    = 1'b1;
        tb_drive = 1'b1;
        tb_wdata = v;
        tick();
        wr_en    = 1'b0;
        tb_drive = 1'b0;
        addr     = '0;
    endtask

    task automatic bus_read(input string name, input logic [AW-1:0] a, input logic [W-1:0] exp);
        addr  = a;
        wr_en = 1'b0;
        #1;
        check(name, data, exp);
        addr = '0;
    endtask

    task automatic drain(input string name, input int exp_cycles);
        int n = 0;
        while (exp_q.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        check(name, n, exp_cycles);
    endtask

    initial begin
        rst       = 1'b1;
        boot      = 1'b0;
        wr_en     = 1'b0;
        addr      = '0;
        out_ready = 1'b0;
        tb_drive  = 1'b0;
        tb_wdata  = '0;

        // Reset and idle
        repeat (3) tick();
        rst = 1'b0;
        check("reset_valid", out_valid, 0);
        bus_read("reset_status", A_STATUS, 8'h02);
        bus_read("idle_data_reg", A_DATA, 8'h00);
        bus_read("idle_other_addr", 8'h00, UNDRIVEN);
        bus_read("idle_f2_addr", 8'hF2, UNDRIVEN);

        // Single write: count 1, stalled, not empty -> 0x18
        exp_q.push_back(8'h5A);
        bus_write(A_DATA, 8'h5A);
        check("single_valid", out_valid, 1);
        check("single_head", out_data, 8'h5A);
        bus_read("single_status", A_STATUS, 8'h18);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("single_popped", out_valid, 0);

        // Fill and overflow: 5 is dropped
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(W'(i));
            bus_write(A_DATA, W'(i));
        end
        bus_read("ovf_status", A_STATUS, 8'h4D);
        out_ready = 1'b1;
        drain("ovf_drain_cycles", 4);
        check("ovf_no_fifth", out_valid, 0);
        out_ready = 1'b0;
        bus_read("ovf_sticky_status", A_STATUS, 8'h06);
        bus_write(A_STATUS, 8'hFF);
        bus_read("ovf_cleared_status", A_STATUS, 8'h02);

        // Push and pop together while full
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(W'(8'hB1 + i));
            bus_write(A_DATA, W'(8'hB1 + i));
        end
        out_ready = 1'b1;
        exp_q.push_back(8'hAA);
        bus_write(A_DATA, 8'hAA);
        out_ready = 1'b0;
        bus_read("full_pushpop_status", A_STATUS, 8'h49);
        out_ready = 1'b1;
        drain("full_pushpop_drain", 4);
        check("full_pushpop_empty", out_valid, 0);
        out_ready = 1'b0;

        // Boot masking
        boot = 1'b1;
        bus_write(A_DATA, 8'h77);
        bus_read("boot_status_released", A_STATUS, UNDRIVEN);
        check("boot_no_push", out_valid, 0);
        boot = 1'b0;
        bus_read("boot_after_status", A_STATUS, 8'h02);
        exp_q.push_back(8'h3C);
        bus_write(A_DATA, 8'h3C);
        check("post_boot_valid", out_valid, 1);
        out_ready = 1'b1;
        drain("post_boot_drain", 1);
        out_ready = 1'b0;

        // Reset mid-stream discards queued words
        for (int i = 0; i < 3; i++) begin
            bus_write(A_DATA, W'(8'h21 + i));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        bus_read("midrst_status", A_STATUS, 8'h02);
        exp_q.push_back(8'h11);
        bus_write(A_DATA, 8'h11);
        out_ready = 1'b1;
        drain("midrst_drain", 1);
        out_ready = 1'b0;
        tick();

        check("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
